sound_sequencer: RTL and testbench

//  Shares the single packed sound-clip ROM (win/moo/detect/cheer) among four game-event requesters.

---
 rtl/sound_sequencer.sv | 117 +++++++++++
 tb/tb_sound_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Arbitrates four clip requests onto one ROM by fixed priority with pre-emption; rom_addr steps every TICK_DIV cycles.
// Sample reaches the audio port 2 cycles after its address; write_audio_out follows audio_out_allowed and never stalls the FSM.
module sound_sequencer #(
    parameter int ADDR_W   = 18,
    parameter int SAMPLE_W = 6,
    parameter int TICK_DIV = 1200,
    parameter logic [4*ADDR_W-1:0] CLIP_START = {18'd83255, 18'd66983, 18'd16396, 18'd0},
    parameter logic [4*ADDR_W-1:0] CLIP_END   = {18'd137138, 18'd83254, 18'd66982, 18'd16395}
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [3:0]          sound_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [31:0]         left_channel_audio_out,
    output logic [31:0]         right_channel_audio_out,
    output logic                busy,
    output logic [1:0]          active_clip,
    output logic                clip_done
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    logic [0:0]          state;
    logic [3:0]          pending;
    logic [TICK_W-1:0]   tick;
    logic [SAMPLE_W-1:0] sample;

    logic       has_pend;
    logic [1:0] pick;
    logic       tick_last;
    logic       at_end;
    logic       preempt;
    logic       load;
    logic       done_now;
    logic [3:0] clr_mask;

    function automatic logic [ADDR_W-1:0] clip_start(input logic [1:0] idx);
        return CLIP_START[int'(idx)*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] clip_end(input logic [1:0] idx);
        return CLIP_END[int'(idx)*ADDR_W +: ADDR_W];
    endfunction

    // Lowest set index wins.
    always_comb begin
        has_pend = |pending;
        pick     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) pick = 2'(i);
        end
    end

    assign tick_last = (tick == TICK_W'(TICK_DIV - 1));
    assign at_end    = (rom_addr == clip_end(active_clip));
    assign preempt   = (state == PLAY) && has_pend && (pick < active_clip);

    always_comb begin
        load     = 1'b0;
        done_now = 1'b0;
        if (state == IDLE) begin
            load = has_pend;
        end else if (preempt) begin
            load = 1'b1;
        end else if (tick_last && at_end) begin
            done_now = 1'b1;
            load     = has_pend;
        end
    end

    assign clr_mask = load ? (4'b0001 << pick) : 4'b0000;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 4'b0000;
            rom_addr    <= '0;
            tick        <= '0;
            sample      <= '0;
            active_clip <= 2'd0;
            clip_done   <= 1'b0;
        end else begin
            // A request arriving on its own clear cycle survives.
            pending   <= (pending & ~clr_mask) | sound_req;
            clip_done <= done_now;
            sample    <= (state == PLAY) ? rom_q : '0;
            if (load) begin
                state       <= PLAY;
                rom_addr    <= clip_start(pick);
                active_clip <= pick;
                tick        <= '0;
            end else if (state == PLAY) begin
                if (done_now) begin
                    state    <= IDLE;
                    rom_addr <= '0;
                    tick     <= '0;
                end else if (tick_last) begin
                    rom_addr <= rom_addr + 1'b1;
                    tick     <= '0;
                end else begin
                    tick <= tick + 1'b1;
                end
            end
        end
    end

    assign busy                    = (state == PLAY);
    assign write_audio_out         = audio_out_allowed & ~reset;
    assign left_channel_audio_out  = {sample, {(32-SAMPLE_W){1'b0}}};
    assign right_channel_audio_out = 32'd0;

endmodule

// File: tb/tb_sound_sequencer.sv
// Randomized and directed bench for sound_sequencer with a shortened clip map and tick divider.
module tb_sound_sequencer;

    localparam int AW = 18;
    localparam int SW = 6;
    localparam int TD = 4;
    localparam logic [4*AW-1:0] CS = {18'd40, 18'd22, 18'd10, 18'd0};
    localparam logic [4*AW-1:0] CE = {18'd47, 18'd39, 18'd21, 18'd9};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    sound_req = 4'b0;
    logic [AW-1:0] rom_addr;
    logic [SW-1:0] rom_q;
    logic          audio_out_allowed = 1'b1;
    logic          write_audio_out;
    logic [31:0]   left_channel_audio_out;
    logic [31:0]   right_channel_audio_out;
    logic          busy;
    logic [1:0]    active_clip;
    logic          clip_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sound_sequencer #(
        .ADDR_W(AW), .SAMPLE_W(SW), .TICK_DIV(TD), .CLIP_START(CS), .CLIP_END(CE)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .sound_req(sound_req),
        .rom_addr(rom_addr),
        .rom_q(rom_q),
        .audio_out_allowed(audio_out_allowed),
        .write_audio_out(write_audio_out),
        .left_channel_audio_out(left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .busy(busy),
        .active_clip(active_clip),
        .clip_done(clip_done)
    );

    // Registered ROM whose data is the low address bits.
    always @(posedge clk) rom_q <= rom_addr[5:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: clip table, pending set, position inside clip.
    int   m_start[4] = '{0, 10, 22, 40};
    int   m_end[4]   = '{9, 21, 39, 47};
    bit   model_on = 1'b0;
    bit   m_busy = 1'b0;
    int   m_addr = 0;
    int   m_tick = 0;
    int   m_clip = 0;
    bit [3:0] m_pend = 4'b0;
    bit   m_done = 1'b0;
    int   a_prev = 0;
    int   m_sample = 0;

    function automatic int first_set(input bit [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return 4;
    endfunction

    always @(posedge clk) begin
        int nxt;
        if (reset) begin
            model_on = 1'b1;
            m_sample = 0;
            a_prev   = m_addr;
            m_busy   = 1'b0;
            m_addr   = 0;
            m_tick   = 0;
            m_clip   = 0;
            m_pend   = 4'b0;
            m_done   = 1'b0;
        end else begin
            nxt      = -1;
            m_done   = 1'b0;
            m_sample = m_busy ? (a_prev % 64) : 0;
            a_prev   = m_addr;
            if (!m_busy) begin
                if (m_pend != 0) nxt = first_set(m_pend);
            end else if (first_set(m_pend) < m_clip) begin
                nxt = first_set(m_pend);
            end else if (m_tick == TD - 1) begin
                if (m_addr < m_end[m_clip]) begin
                    m_addr++;
                    m_tick = 0;
                end else begin
                    m_done = 1'b1;
                    if (m_pend != 0) nxt = first_set(m_pend);
                    else begin
                        m_busy = 1'b0;
                        m_addr = 0;
                        m_tick = 0;
                    end
                end
            end else begin
                m_tick++;
            end
            if (nxt >= 0) begin
                m_busy = 1'b1;
                m_clip = nxt;
                m_addr = m_start[nxt];
                m_tick = 0;
                m_pend[nxt] = 1'b0;
            end
            m_pend = m_pend | sound_req;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("busy", busy, m_busy);
            check("active_clip", active_clip, m_clip);
            check("rom_addr", rom_addr, m_addr);
            check("clip_done", clip_done, m_done);
            check("left", left_channel_audio_out, {m_sample[5:0], 26'b0});
            check("right", right_channel_audio_out, 0);
            check("write", write_audio_out, audio_out_allowed & ~reset);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [3:0] r);
        sound_req = r;
        cyc(1);
        sound_req = 4'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (clip_done !== 1'b1 && n < 500);
        check("wait_done", clip_done, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_left", left_channel_audio_out, 0);

        // Win plays to completion.
        pulse(4'b0001);
        cyc(1);
        check("t1_busy", busy, 1);
        check("t1_clip", active_clip, 0);
        check("t1_addr0", rom_addr, 0);
        cyc(4);
        check("t1_addr1", rom_addr, 1);
        wait_done(n);
        check("t1_len", n, 36);
        check("t1_idle", busy, 0);
        check("t1_addr_idle", rom_addr, 0);

        // Cheer pre-empted by win.
        pulse(4'b1000);
        cyc(1);
        check("t2_cheer", rom_addr, 40);
        cyc(20);
        check("t2_cheer5", rom_addr, 45);
        pulse(4'b0001);
        cyc(1);
        check("t2_clip", active_clip, 0);
        check("t2_addr", rom_addr, 0);
        wait_done(n);
        check("t2_len", n, 40);
        cyc(3);
        check("t2_no_resume", busy, 0);

        // Moo then detect back to back.
        pulse(4'b0110);
        cyc(1);
        check("t3_moo", rom_addr, 10);
        wait_done(n);
        check("t3_len", n, 48);
        check("t3_detect_addr", rom_addr, 22);
        check("t3_detect_clip", active_clip, 2);
        wait_done(n);
        check("t3_len2", n, 72);
        check("t3_idle", busy, 0);

        // Moo re-requested while playing replays once.
        pulse(4'b0010);
        cyc(1);
        cyc(10);
        pulse(4'b0010);
        wait_done(n);
        check("t4_len", n, 37);
        check("t4_replay_addr", rom_addr, 10);
        check("t4_replay_busy", busy, 1);
        wait_done(n);
        check("t4_len2", n, 48);
        check("t4_idle", busy, 0);

        // Backpressure on the audio port.
        pulse(4'b0100);
        cyc(1);
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            check("t5_write", write_audio_out, 0);
        end
        audio_out_allowed = 1'b1;
        wait_done(n);

        // Reset mid-clip drops playing and pending clips.
        pulse(4'b0100);
        cyc(16);
        pulse(4'b1000);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_addr", rom_addr, 0);
        check("t6_left", left_channel_audio_out, 0);
        check("t6_done", clip_done, 0);
        cyc(10);
        check("t6_pend_cleared", busy, 0);

        for (int i = 0; i < 3000; i++) begin
            sound_req         = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            audio_out_allowed = ($urandom_range(0, 3) != 0);
            reset             = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        reset = 1'b0;
        sound_req = 4'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
